lamp_input_events: RTL and testbench

Input front end for the automatic-lighting controller. It synchronises and debounces the raw push-button and the infrared presence sensor, and classifies button presses as short or long. It also runs the inactivity timer that is enabled by the lamp controller while the lamp is on in automatic mode. Its outputs are the four condition inputs of the lamp state machine: long press, short press, timeout and presence.

---
 rtl/lamp_pkg.sv | 16 +
 rtl/lamp_input_events_sync_debounce.sv | 48 ++++
 rtl/lamp_input_events.sv | 110 +++++++++++
 tb/tb_lamp_input_events.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lamp_pkg.sv
// Shared types and default timing for the lamp input front end.
// Defaults assume a 1 kHz clock.
package lamp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
  } press_state_t;

  localparam int DEF_DEBOUNCE_CYC     = 20;
  localparam int DEF_SHORT_MIN_CYC    = 300;
  localparam int DEF_LONG_MIN_CYC     = 5000;
  localparam int DEF_IDLE_TIMEOUT_CYC = 30000;

endpackage

// File: rtl/lamp_input_events_sync_debounce.sv
// Two-flop synchroniser followed by a stability-count debouncer.
// DEBOUNCE_CYC = 0 leaves only the synchroniser, so the output is still registered.
module sync_debounce #(
  parameter int DEBOUNCE_CYC = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], raw};
  end

  generate
    if (DEBOUNCE_CYC == 0) begin : g_bypass
      assign level = sync_q[1];
    end else begin : g_db
      localparam int CW = $clog2(DEBOUNCE_CYC + 1);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

      logic [CW-1:0] cnt;
      logic          db;

      // Flip on the edge that would make the disagreement run DEBOUNCE_CYC long.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt <= '0;
          db  <= 1'b0;
        end else if (sync_q[1] == db) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          db  <= sync_q[1];
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign level = db;
    end
  endgenerate

endmodule

// File: rtl/lamp_input_events.sv
// Button / presence front end for the lamp controller: press classification
// into short and long pulses, plus the inactivity timeout timer.
module lamp_input_events
  import lamp_pkg::*;
#(
  parameter int DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
  parameter int SHORT_MIN_CYC    = DEF_SHORT_MIN_CYC,
  parameter int LONG_MIN_CYC     = DEF_LONG_MIN_CYC,
  parameter int IDLE_TIMEOUT_CYC = DEF_IDLE_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic infra,
  input  logic timer_en,
  output logic long_press,
  output logic short_press,
  output logic timeout,
  output logic presence
);

  localparam int PW = $clog2(LONG_MIN_CYC + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT_CYC + 1);
  localparam logic [PW-1:0] LONG_CNT  = PW'(LONG_MIN_CYC);
  localparam logic [PW-1:0] SHORT_CNT = PW'(SHORT_MIN_CYC);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT_CYC - 1);

  logic push_db;

  sync_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_push (
    .clk   (clk),
    .rst   (rst),
    .raw   (push),
    .level (push_db)
  );

  sync_debounce #(.DEBOUNCE_CYC(0)) u_infra (
    .clk   (clk),
    .rst   (rst),
    .raw   (infra),
    .level (presence)
  );

  press_state_t  state;
  logic [PW-1:0] press_cnt;
  logic [PW-1:0] press_nxt;

  assign press_nxt = (press_cnt == LONG_CNT) ? press_cnt : press_cnt + 1'b1;

  // press_cnt equals the number of push_db-high cycles seen so far, so a
  // press of exactly LONG_MIN_CYC goes long before its release is observed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      press_cnt   <= '0;
      long_press  <= 1'b0;
      short_press <= 1'b0;
    end else begin
      long_press  <= 1'b0;
      short_press <= 1'b0;
      case (state)
        IDLE, PRESSED: begin
          if (push_db) begin
            press_cnt <= press_nxt;
            if (press_nxt == LONG_CNT) begin
              long_press <= 1'b1;
              state      <= HELD;
            end else begin
              state <= PRESSED;
            end
          end else begin
            if (state == PRESSED && press_cnt > SHORT_CNT) short_press <= 1'b1;
            press_cnt <= '0;
            state     <= IDLE;
          end
        end
        HELD: begin
          if (!push_db) begin
            press_cnt <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          press_cnt <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

  logic [IW-1:0] idle_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (!timer_en || presence) begin
        idle_cnt <= '0;
      end else if (idle_cnt == IDLE_LAST) begin
        timeout  <= 1'b1;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lamp_input_events.sv
// Window-based bench: stimulus arrays are replayed from reset and the pulse
// trace is compared against times derived from press durations and idle streaks.
module tb_lamp_input_events;

  localparam int D    = 4;
  localparam int SH   = 10;
  localparam int LG   = 50;
  localparam int TO   = 100;
  localparam int MAXL = 1600;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic push = 1'b0;
  logic infra = 1'b0;
  logic timer_en = 1'b0;
  logic long_press, short_press, timeout, presence;

  int n_chk = 0;
  int n_bad = 0;

  bit   p_a [MAXL];
  bit   te_a[MAXL];
  bit   in_a[MAXL];
  bit   ex_lp[MAXL], ex_sp[MAXL], ex_to[MAXL], ex_pr[MAXL];
  logic ob_lp[MAXL], ob_sp[MAXL], ob_to[MAXL], ob_pr[MAXL];

  lamp_input_events #(
    .DEBOUNCE_CYC     (D),
    .SHORT_MIN_CYC    (SH),
    .LONG_MIN_CYC     (LG),
    .IDLE_TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .infra       (infra),
    .timer_en    (timer_en),
    .long_press  (long_press),
    .short_press (short_press),
    .timeout     (timeout),
    .presence    (presence)
  );

  always #5 clk = ~clk;

  task automatic clear_stim();
    for (int i = 0; i < MAXL; i++) begin
      p_a[i] = 1'b0; te_a[i] = 1'b0; in_a[i] = 1'b0;
    end
  endtask

  // Presses: a high run of n >= D raw cycles is a press of n cycles; its
  // debounced edges lag the raw ones by 2 + D cycles.
  task automatic model(input int L);
    int streak, r, f, n, c;
    for (int i = 0; i < L; i++) begin
      ex_lp[i] = 1'b0; ex_sp[i] = 1'b0; ex_to[i] = 1'b0; ex_pr[i] = 1'b0;
      if (i >= 2) ex_pr[i] = in_a[i-2];
    end
    streak = 0;
    for (int i = 0; i < L; i++) begin
      if (te_a[i] && !ex_pr[i]) streak++;
      else streak = 0;
      if (streak > 0 && streak % TO == 0 && i + 1 < L) ex_to[i+1] = 1'b1;
    end
    c = 0;
    while (c < L) begin
      if (!p_a[c]) c++;
      else begin
        r = c;
        while (c < L && p_a[c]) c++;
        f = c;
        n = f - r;
        if (n >= LG) begin
          if (r + 2 + D + LG < L) ex_lp[r+2+D+LG] = 1'b1;
        end else if (n >= D && n > SH && f < L && f + 3 + D < L) begin
          ex_sp[f+3+D] = 1'b1;
        end
      end
    end
  endtask

  // Cycle c starts at the edge right after reset release; inputs of cycle c
  // are sampled at edge c+1, outputs of cycle c are read at its falling edge.
  task automatic run_window(input int L);
    rst = 1'b1;
    push = p_a[0]; timer_en = te_a[0]; infra = in_a[0];
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < L; c++) begin
      push = p_a[c]; timer_en = te_a[c]; infra = in_a[c];
      @(negedge clk);
      ob_lp[c] = long_press; ob_sp[c] = short_press;
      ob_to[c] = timeout;    ob_pr[c] = presence;
      @(posedge clk);
      #1;
    end
    model(L);
  endtask

  function automatic int count_ob(input int sel, input int L);
    int k = 0;
    for (int i = 0; i < L; i++) begin
      if (sel == 0 && ob_lp[i] === 1'b1) k++;
      if (sel == 1 && ob_sp[i] === 1'b1) k++;
      if (sel == 2 && ob_to[i] === 1'b1) k++;
    end
    return k;
  endfunction

  task automatic test_reset();
    int L = 130;
    clear_stim();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; push = 1'b1; timer_en = 1'b1; infra = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (presence !== 1'b1) begin
      n_bad++; $display("FAIL reset_pre_presence got=%b expected=1", presence);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if ({long_press, short_press, timeout, presence} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_async got=%b expected=0000", {long_press, short_press, timeout, presence});
    end
    for (int c = 0; c < L; c++) begin p_a[c] = 1'b1; te_a[c] = 1'b1; end
    run_window(L);
    for (int c = 0; c < L; c++) begin
      n_chk++;
      if ({ob_lp[c], ob_sp[c], ob_to[c], ob_pr[c]} !== {ex_lp[c], ex_sp[c], ex_to[c], ex_pr[c]}) begin
        n_bad++;
        $display("FAIL reset_trace cycle=%0d got=%b expected=%b", c,
                 {ob_lp[c], ob_sp[c], ob_to[c], ob_pr[c]}, {ex_lp[c], ex_sp[c], ex_to[c], ex_pr[c]});
      end
    end
    n_chk++;
    if (ob_lp[2+D+LG] !== 1'b1 || count_ob(0, L) != 1) begin
      n_bad++; $display("FAIL reset_held_long count=%0d expected=1 at cycle %0d", count_ob(0, L), 2 + D + LG);
    end
    n_chk++;
    if (ob_to[TO] !== 1'b1) begin
      n_bad++; $display("FAIL reset_timeout got=%b expected=1 at cycle %0d", ob_to[TO], TO);
    end
  endtask

  task automatic test_bounce();
    int L = 60;
    clear_stim();
    for (int c = 5; c < 35; c++) p_a[c] = ((c - 5) % 4) < 2;
    run_window(L);
    for (int c = 0; c < L; c++) begin
      n_chk++;
      if ({ob_lp[c], ob_sp[c], ob_to[c]} !== {ex_lp[c], ex_sp[c], ex_to[c]}) begin
        n_bad++;
        $display("FAIL bounce_trace cycle=%0d got=%b expected=%b", c,
                 {ob_lp[c], ob_sp[c], ob_to[c]}, {ex_lp[c], ex_sp[c], ex_to[c]});
      end
    end
    n_chk++;
    if (count_ob(0, L) + count_ob(1, L) != 0) begin
      n_bad++; $display("FAIL bounce_pulses got=%0d expected=0", count_ob(0, L) + count_ob(1, L));
    end
  endtask

  // dur: raw press length; want_lp/want_sp: pulse counts for that length.
  task automatic test_press(input string name, input int dur, input int want_lp, input int want_sp);
    int L = dur + 50;
    clear_stim();
    for (int c = 5; c < 5 + dur; c++) p_a[c] = 1'b1;
    run_window(L);
    for (int c = 0; c < L; c++) begin
      n_chk++;
      if ({ob_lp[c], ob_sp[c], ob_to[c], ob_pr[c]} !== {ex_lp[c], ex_sp[c], ex_to[c], ex_pr[c]}) begin
        n_bad++;
        $display("FAIL %s_trace cycle=%0d got=%b expected=%b", name, c,
                 {ob_lp[c], ob_sp[c], ob_to[c], ob_pr[c]}, {ex_lp[c], ex_sp[c], ex_to[c], ex_pr[c]});
      end
    end
    n_chk++;
    if (count_ob(0, L) != want_lp || count_ob(1, L) != want_sp) begin
      n_bad++;
      $display("FAIL %s_counts got long=%0d short=%0d expected long=%0d short=%0d",
               name, count_ob(0, L), count_ob(1, L), want_lp, want_sp);
    end
  endtask

  task automatic test_timer();
    int L = 540;
    clear_stim();
    for (int c = 0; c < 400; c++) te_a[c] = 1'b1;
    for (int c = 250; c < 253; c++) in_a[c] = 1'b1;
    for (int c = 440; c < 520; c++) te_a[c] = 1'b1;
    run_window(L);
    for (int c = 0; c < L; c++) begin
      n_chk++;
      if ({ob_lp[c], ob_sp[c], ob_to[c], ob_pr[c]} !== {ex_lp[c], ex_sp[c], ex_to[c], ex_pr[c]}) begin
        n_bad++;
        $display("FAIL timer_trace cycle=%0d got=%b expected=%b", c,
                 {ob_lp[c], ob_sp[c], ob_to[c], ob_pr[c]}, {ex_lp[c], ex_sp[c], ex_to[c], ex_pr[c]});
      end
    end
    n_chk++;
    if (ob_to[100] !== 1'b1 || ob_to[200] !== 1'b1 || ob_to[355] !== 1'b1 || count_ob(2, L) != 3) begin
      n_bad++;
      $display("FAIL timer_points got t100=%b t200=%b t355=%b count=%0d expected 1 1 1 count=3",
               ob_to[100], ob_to[200], ob_to[355], count_ob(2, L));
    end
  endtask

  task automatic test_random(input int L);
    int c, n, len;
    bit on;
    clear_stim();
    c = 10;
    while (c < L - 200) begin
      c += $urandom_range(30, D);
      case ($urandom_range(3, 0))
        0:       n = $urandom_range(D - 1, 1);
        1:       n = $urandom_range(SH + 2, D);
        2:       n = $urandom_range(LG - 1, SH + 1);
        default: n = $urandom_range(LG + 25, LG);
      endcase
      for (int k = 0; k < n; k++) p_a[c+k] = 1'b1;
      c += n;
    end
    c = 0;
    while (c < L) begin
      len = $urandom_range(300, 50);
      on  = ($urandom_range(3, 0) != 0);
      for (int k = 0; k < len && c < L; k++) begin
        te_a[c] = on;
        in_a[c] = ($urandom_range(149, 0) == 0);
        c++;
      end
    end
    run_window(L);
    for (int i = 0; i < L; i++) begin
      n_chk++;
      if ({ob_lp[i], ob_sp[i], ob_to[i], ob_pr[i]} !== {ex_lp[i], ex_sp[i], ex_to[i], ex_pr[i]}) begin
        n_bad++;
        $display("FAIL random_trace cycle=%0d got=%b expected=%b", i,
                 {ob_lp[i], ob_sp[i], ob_to[i], ob_pr[i]}, {ex_lp[i], ex_sp[i], ex_to[i], ex_pr[i]});
      end
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_press("short", 20, 0, 1);
    test_press("too_short", 8, 0, 0);
    test_press("edge_short", SH, 0, 0);
    test_press("min_short", SH + 1, 0, 1);
    test_press("long", 80, 1, 0);
    test_press("exact_long", LG, 1, 0);
    test_press("max_short", LG - 1, 0, 1);
    test_timer();
    test_random(1500);
    test_random(1500);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
